// File: rtl/ltsm_trainerror_pkg.sv
// ltsm_trainerror_pkg: shared TRAINERROR message codes, state encoding and defaults
package ltsm_trainerror_pkg;
  localparam int TE_ENTRY_REQ = 15;
  localparam int TE_ENTRY_RESP = 14;
  localparam int TE_TIMEOUT_CYCLES = 8000;
  localparam logic [2:0] TE_ST_IDLE = 3'd0;
  localparam logic [2:0] TE_ST_SEND_REQ = 3'd1;
  localparam logic [2:0] TE_ST_WAIT_RESP = 3'd2;
  localparam logic [2:0] TE_ST_TEST_FINISHED = 3'd3;
  localparam logic [2:0] TE_ST_TIMEOUT = 3'd4;
  typedef enum logic [2:0] {
    ST_IDLE = TE_ST_IDLE,
    ST_SEND_REQ = TE_ST_SEND_REQ,
    ST_WAIT_RESP = TE_ST_WAIT_RESP,
    ST_TEST_FINISHED = TE_ST_TEST_FINISHED,
    ST_TIMEOUT = TE_ST_TIMEOUT
  } te_state_e;
  function automatic logic te_is_active(te_state_e s);
    return s == ST_SEND_REQ || s == ST_WAIT_RESP;
  endfunction
endpackage

// File: rtl/ltsm_timeout_counter.sv
// ltsm_timeout_counter: saturating cycle counter flagging the last allowed cycle
module ltsm_timeout_counter #(
  parameter int LIMIT = 8000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  // Clear wins; otherwise count while enabled and stop at the last cycle
  always_comb cnt_d = i_clear ? '0 : (i_enable && cnt_q != LAST) ? cnt_q + 1'b1 : cnt_q;
  // Counter register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign o_expired = i_enable && cnt_q == LAST;
endmodule

// File: rtl/tx_trainerror_hs.sv
// tx_trainerror_hs: initiator side of the TRAINERROR entry request/response handshake
module tx_trainerror_hs
  import ltsm_trainerror_pkg::*;
#(
  parameter int SB_MSG_WIDTH = 4,
  parameter int TIMEOUT_CYCLES = TE_TIMEOUT_CYCLES
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_trainerror_en,
  input  logic                    i_rx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic                    i_SB_Busy,
  input  logic                    i_falling_edge_busy,
  input  logic                    i_rx_valid,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx,
  output logic                    o_valid_tx,
  output logic                    o_trainerror_end_tx,
  output logic                    o_timeout_tx
);
  te_state_e state_q, state_d;
  logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
  logic valid_q, valid_d, valid_prev_q, pending_q, pending_d;
  logic resp_seen_q, resp_seen_d, end_q, end_d, timeout_q, timeout_d;
  logic sb_free, resp_now, active, done, expired;
  assign sb_free = !i_SB_Busy && !i_rx_valid;
  assign resp_now = i_rx_msg_valid && i_decoded_SB_msg == SB_MSG_WIDTH'(TE_ENTRY_RESP);
  assign active = te_is_active(state_q);
  assign done = state_q == ST_WAIT_RESP && (resp_seen_q || resp_now);
  ltsm_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (state_q == ST_IDLE),
    .i_enable (active),
    .o_expired(expired)
  );
  // Next state and next registered outputs; losing the enable aborts from anywhere
  always_comb begin
    state_d = state_q;
    msg_d = msg_q;
    valid_d = valid_q;
    pending_d = pending_q;
    resp_seen_d = resp_seen_q;
    end_d = end_q;
    timeout_d = timeout_q;
    if (state_q == ST_IDLE || !i_trainerror_en) begin
      state_d = i_trainerror_en ? ST_SEND_REQ : ST_IDLE;
      msg_d = i_trainerror_en ? SB_MSG_WIDTH'(TE_ENTRY_REQ) : '0;
      valid_d = i_trainerror_en && state_q == ST_IDLE && sb_free;
      pending_d = i_trainerror_en && state_q == ST_IDLE && !sb_free;
      resp_seen_d = 1'b0;
      end_d = 1'b0;
      timeout_d = 1'b0;
      if (state_q != ST_IDLE) state_d = ST_IDLE;
    end else if (active) begin
      resp_seen_d = resp_seen_q || resp_now;
      if (done) begin
        state_d = ST_TEST_FINISHED;
        end_d = 1'b1;
      end else if (expired) begin
        state_d = ST_TIMEOUT;
        timeout_d = 1'b1;
        valid_d = 1'b0;
        pending_d = 1'b0;
      end else begin
        if (i_falling_edge_busy) valid_d = 1'b0;
        else if (pending_q && sb_free) begin
          valid_d = 1'b1;
          pending_d = 1'b0;
        end
        if (state_q == ST_SEND_REQ && valid_prev_q && !valid_q) state_d = ST_WAIT_RESP;
      end
    end
  end
  // All state and outputs are registered together
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      msg_q <= '0;
      valid_q <= 1'b0;
      valid_prev_q <= 1'b0;
      pending_q <= 1'b0;
      resp_seen_q <= 1'b0;
      end_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q <= msg_d;
      valid_q <= valid_d;
      valid_prev_q <= valid_q;
      pending_q <= pending_d;
      resp_seen_q <= resp_seen_d;
      end_q <= end_d;
      timeout_q <= timeout_d;
    end
  end
  assign o_encoded_SB_msg_tx = msg_q;
  assign o_valid_tx = valid_q;
  assign o_trainerror_end_tx = end_q;
  assign o_timeout_tx = timeout_q;
endmodule
